// File: rtl/maria_bus_sched.sv
// Per-scanline bus scheduler between the 6502 and MARIA DMA: HALT/RDY sequencing,
// address-bus handover, WSYNC line stalls and the DLI NMI pulse.
module maria_bus_sched #(
   parameter int HALT_SETUP  = 2,
   parameter int RELEASE_GAP = 1,
   parameter int NMI_WIDTH   = 8
) (
   input  logic       clk_sys,
   input  logic       reset_n,
   input  logic       mclk0,
   input  logic       pclkp,
   input  logic       maria_en,
   input  logic [1:0] dma_mode,
   input  logic       wsync,
   input  logic       line_start,
   input  logic       dma_req,
   input  logic       dma_done,
   input  logic       dli_req,
   output logic       halt_n,
   output logic       cpu_rdy,
   output logic       drive_AB,
   output logic       dma_go,
   output logic       nmi_n,
   output logic       busy
);

   if (HALT_SETUP < 1 || HALT_SETUP > 15 || RELEASE_GAP < 1 || RELEASE_GAP > 15 ||
       NMI_WIDTH < 1 || NMI_WIDTH > 15) begin : g_param_check
      $error("maria_bus_sched: HALT_SETUP, RELEASE_GAP and NMI_WIDTH must be 1..15");
   end

   localparam logic [3:0] SETUP_LD   = 4'(HALT_SETUP - 1);
   localparam logic [3:0] RELEASE_LD = 4'(RELEASE_GAP - 1);
   localparam logic [3:0] NMI_LD     = 4'(NMI_WIDTH);

   typedef enum logic [1:0] {IDLE, HALT_SETUP_S, DMA, RELEASE} state_t;

   state_t     state, state_nx;
   logic [3:0] cnt, cnt_nx;
   logic       dma_pend, pend_nx;
   logic       halt_nx, drive_nx, go_nx;
   logic       dma_ok;
   logic       wsync_pend;
   logic       wsync_hit;
   logic [3:0] nmi_cnt;

   assign dma_ok    = (dma_mode == 2'b10);
   assign wsync_hit = pclkp & wsync;
   assign busy      = (state != IDLE);

   // State register: 2600 mode parks the scheduler in IDLE.
   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n)      state <= IDLE;
      else if (!maria_en) state <= IDLE;
      else if (mclk0)    state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:         if (dma_req && dma_ok) state_nx = HALT_SETUP_S;
         HALT_SETUP_S: if (cnt == 4'd0) state_nx = DMA;
         DMA:          if (dma_done) state_nx = RELEASE;
         RELEASE:      if (cnt == 4'd0)
                          state_nx = ((dma_pend || dma_req) && dma_ok) ? HALT_SETUP_S : IDLE;
         default:      state_nx = IDLE;
      endcase
   end

   // Next values for the registered outputs, counter and pending flag.
   always_comb begin
      halt_nx  = (state_nx == IDLE);
      drive_nx = (state_nx == DMA);
      go_nx    = (state == HALT_SETUP_S) && (state_nx == DMA);
      cnt_nx   = (cnt == 4'd0) ? 4'd0 : cnt - 4'd1;
      if (state_nx == HALT_SETUP_S && state != HALT_SETUP_S) cnt_nx = SETUP_LD;
      if (state_nx == RELEASE && state == DMA)               cnt_nx = RELEASE_LD;
      pend_nx = dma_pend;
      // Leaving RELEASE either consumes the queued request or drops it.
      if (state == RELEASE && state_nx != RELEASE) pend_nx = 1'b0;
      else if (state != IDLE && dma_req)           pend_nx = 1'b1;
   end

   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         halt_n   <= 1'b1;
         drive_AB <= 1'b0;
         dma_go   <= 1'b0;
         cnt      <= 4'd0;
         dma_pend <= 1'b0;
      end else if (!maria_en) begin
         halt_n   <= 1'b1;
         drive_AB <= 1'b0;
         dma_go   <= 1'b0;
         cnt      <= 4'd0;
         dma_pend <= 1'b0;
      end else if (mclk0) begin
         halt_n   <= halt_nx;
         drive_AB <= drive_nx;
         dma_go   <= go_nx;
         cnt      <= cnt_nx;
         dma_pend <= pend_nx;
      end
   end

   // WSYNC: a write landing on the line_start tick must wait for the following line.
   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         wsync_pend <= 1'b0;
         cpu_rdy    <= 1'b1;
      end else if (!maria_en) begin
         wsync_pend <= 1'b0;
         cpu_rdy    <= 1'b1;
      end else if (mclk0) begin
         if (line_start) begin
            wsync_pend <= wsync_hit;
            cpu_rdy    <= 1'b1;
         end else begin
            wsync_pend <= wsync_pend | wsync_hit;
            cpu_rdy    <= ~wsync_pend;
         end
      end else if (wsync_hit) begin
         wsync_pend <= 1'b1;
      end
   end

   // DLI reload during an active pulse only stretches it.
   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         nmi_cnt <= 4'd0;
         nmi_n   <= 1'b1;
      end else if (!maria_en) begin
         nmi_cnt <= 4'd0;
         nmi_n   <= 1'b1;
      end else if (mclk0) begin
         if (dli_req) begin
            nmi_cnt <= NMI_LD;
            nmi_n   <= 1'b0;
         end else if (nmi_cnt != 4'd0) begin
            nmi_cnt <= nmi_cnt - 4'd1;
            if (nmi_cnt == 4'd1) nmi_n <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_maria_bus_sched.sv
// Bench for maria_bus_sched: directed scenarios then random traffic, checked against
// a timestamp-based model of the scanline schedule.
module tb_maria_bus_sched;
   localparam int HS = 2;
   localparam int RG = 1;
   localparam int NW = 8;

   logic       clk_sys = 1'b0;
   logic       reset_n, mclk0, pclkp, maria_en, wsync, line_start, dma_req, dma_done, dli_req;
   logic [1:0] dma_mode;
   logic       halt_n, cpu_rdy, drive_AB, dma_go, nmi_n, busy;

   always #5 clk_sys = ~clk_sys;

   maria_bus_sched #(.HALT_SETUP(HS), .RELEASE_GAP(RG), .NMI_WIDTH(NW)) dut (
      .clk_sys(clk_sys), .reset_n(reset_n), .mclk0(mclk0), .pclkp(pclkp),
      .maria_en(maria_en), .dma_mode(dma_mode), .wsync(wsync), .line_start(line_start),
      .dma_req(dma_req), .dma_done(dma_done), .dli_req(dli_req), .halt_n(halt_n),
      .cpu_rdy(cpu_rdy), .drive_AB(drive_AB), .dma_go(dma_go), .nmi_n(nmi_n), .busy(busy)
   );

   int tests = 0;
   int fails = 0;
   int t = 0;

   // Model: one bus sequence described by its timestamps (in mclk0 ticks).
   bit seq, pend, stall;
   int grant_t, done_t, resume_t, last_dli;
   logic e_halt, e_drive, e_go, e_busy, e_rdy, e_nmi;

   // Observation counters for the directed scenarios.
   int go_cnt, last_go_t, nmi_fall, nmi_low, rdy_low;
   logic prev_nmi = 1'b1;

   task automatic chk(input string tag, input logic obs, input logic exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s tick=%0d observed=%b expected=%b", tag, t, obs, exp);
      end
   endtask

   task automatic chk_int(input string tag, input int obs, input int exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic check_all(input string ph);
      chk({ph, "_halt_n"},   halt_n,   e_halt);
      chk({ph, "_drive_AB"}, drive_AB, e_drive);
      chk({ph, "_dma_go"},   dma_go,   e_go);
      chk({ph, "_busy"},     busy,     e_busy);
      chk({ph, "_cpu_rdy"},  cpu_rdy,  e_rdy);
      chk({ph, "_nmi_n"},    nmi_n,    e_nmi);
   endtask

   task automatic model_clear();
      seq = 0; pend = 0; stall = 0; done_t = -1; last_dli = -1; grant_t = -1; resume_t = -1;
      e_halt = 1; e_drive = 0; e_go = 0; e_busy = 0; e_rdy = 1; e_nmi = 1;
   endtask

   task automatic model_tick(input bit req, done, dli, ls, ws);
      bit ok;
      if (!maria_en) begin
         model_clear();
         return;
      end
      ok = (dma_mode == 2'b10);
      if (seq) begin
         if (done_t >= 0 && t == resume_t) begin
            if ((pend || req) && ok) begin
               grant_t = t + HS; done_t = -1;
            end else seq = 0;
            pend = 0;
         end else begin
            if (req) pend = 1;
            if (done_t < 0 && t > grant_t && done) begin
               done_t = t; resume_t = t + RG;
            end
         end
      end else if (req && ok) begin
         seq = 1; grant_t = t + HS; done_t = -1; pend = 0;
      end
      if (dli) last_dli = t;
      if (ls) begin
         e_rdy = 1; stall = ws;
      end else begin
         e_rdy = !stall; stall = stall | ws;
      end
      e_halt  = !seq;
      e_busy  = seq;
      e_drive = seq && t >= grant_t && done_t < 0;
      e_go    = seq && t == grant_t;
      e_nmi   = !(last_dli >= 0 && t < last_dli + NW);
   endtask

   // One mclk0 tick (enable cycle) followed by one clk_sys cycle with mclk0 low.
   task automatic tick(input bit req, done, dli, ls, ws, wsg);
      @(negedge clk_sys);
      mclk0 = 1; dma_req = req; dma_done = done; dli_req = dli; line_start = ls;
      pclkp = ws; wsync = ws;
      model_tick(req, done, dli, ls, ws);
      @(posedge clk_sys); #1;
      check_all("tick");
      if (dma_go === 1'b1) begin go_cnt++; last_go_t = t; end
      if (nmi_n === 1'b0) nmi_low++;
      if (prev_nmi === 1'b1 && nmi_n === 1'b0) nmi_fall++;
      prev_nmi = nmi_n;
      if (cpu_rdy === 1'b0) rdy_low++;
      @(negedge clk_sys);
      mclk0 = 0; dma_req = 0; dma_done = 0; dli_req = 0; line_start = 0;
      pclkp = wsg; wsync = wsg;
      if (maria_en && wsg) stall = 1;
      @(posedge clk_sys); #1;
      check_all("gap");
      t++;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) tick(0, 0, 0, 0, 0, 0);
   endtask

   task automatic clr_obs();
      go_cnt = 0; last_go_t = -1; nmi_fall = 0; nmi_low = 0; rdy_low = 0;
   endtask

   initial begin
      int base;
      reset_n = 0; mclk0 = 0; pclkp = 0; maria_en = 1; dma_mode = 2'b10; wsync = 0;
      line_start = 0; dma_req = 0; dma_done = 0; dli_req = 0;
      model_clear();
      repeat (2) @(posedge clk_sys);
      #1 check_all("reset");
      @(negedge clk_sys) reset_n = 1;

      // Line DMA: request at +10, done at +30.
      clr_obs(); base = t;
      idle(10); tick(1, 0, 0, 0, 0, 0); idle(19); tick(0, 1, 0, 0, 0, 0); idle(4);
      chk_int("t1_go_count", go_cnt, 1);
      chk_int("t1_go_tick", last_go_t - base, 12);

      // DMA disabled mode drops the request.
      dma_mode = 2'b11;
      tick(1, 0, 0, 0, 0, 0); idle(5);
      chk("t2_busy", busy, 1'b0);
      dma_mode = 2'b10;

      // WSYNC stall to next line, then same-tick wsync/line_start, then gap-cycle wsync.
      clr_obs();
      idle(5); tick(0, 0, 0, 0, 1, 0); idle(34); tick(0, 0, 0, 1, 0, 0); idle(3);
      chk_int("t3_rdy_low", rdy_low, 34);
      clr_obs();
      tick(0, 0, 0, 1, 1, 0); idle(10); tick(0, 0, 0, 1, 0, 0); idle(2);
      chk_int("t3_same_tick_rdy_low", rdy_low, 10);
      tick(0, 0, 0, 0, 0, 1); idle(3); tick(0, 0, 0, 1, 0, 0); idle(2);

      // Queued request during DMA.
      clr_obs(); base = t;
      tick(1, 0, 0, 0, 0, 0); idle(4); tick(1, 0, 0, 0, 0, 0); idle(24);
      tick(0, 1, 0, 0, 0, 0); idle(5); tick(0, 1, 0, 0, 0, 0); idle(4);
      chk_int("t4_go_count", go_cnt, 2);
      chk_int("t4_second_grant", last_go_t - base, 33);

      // DLI retrigger stretches a single NMI pulse.
      clr_obs();
      tick(0, 0, 1, 0, 0, 0); idle(4); tick(0, 0, 1, 0, 0, 0); idle(12);
      chk_int("t5_nmi_edges", nmi_fall, 1);
      chk_int("t5_nmi_low", nmi_low, 13);

      // Async reset mid-DMA, then 2600 mode forcing everything idle.
      tick(1, 0, 0, 0, 0, 0); idle(5);
      @(negedge clk_sys) reset_n = 0;
      #1 model_clear();
      chk("t6_rst_drive_AB", drive_AB, 1'b0);
      chk("t6_rst_halt_n", halt_n, 1'b1);
      @(negedge clk_sys) reset_n = 1;
      tick(1, 0, 1, 0, 1, 0); idle(5);
      maria_en = 0;
      tick(1, 0, 1, 1, 1, 1); tick(0, 1, 0, 0, 1, 0);
      maria_en = 1;
      idle(3);

      // Random traffic.
      for (int i = 0; i < 600; i++) begin
         if ($urandom_range(0, 19) == 0) dma_mode = 2'($urandom_range(0, 3));
         else if ($urandom_range(0, 5) == 0) dma_mode = 2'b10;
         tick($urandom_range(0, 11) == 0, $urandom_range(0, 7) == 0,
              $urandom_range(0, 19) == 0, $urandom_range(0, 29) == 0,
              $urandom_range(0, 14) == 0, $urandom_range(0, 14) == 0);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
